// File: rtl/uart_pkg.sv
// Shared types and helpers for the tick-timed UART transmitter.
package uart_pkg;

  localparam int unsigned DEF_OVERSAMPLE = 16;
  localparam int unsigned DEF_DATA_BITS  = 8;
  localparam int unsigned MAX_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Parity over a zero-extended payload; odd=1 yields odd parity.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_tick_timer.sv
// Counts oversample ticks while a frame runs and flags the tick that closes a bit period.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tick,
  input  logic i_run,
  input  logic i_clear,
  output logic o_bit_end_c
);

  localparam int unsigned CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign o_bit_end_c = i_run & i_tick & (count_q == LAST);

  // Counter is held at zero while idle so the first bit counts only post-accept ticks.
  always_comb begin
    count_d = count_q;
    if (i_clear || !i_run) begin
      count_d = '0;
    end else if (i_tick) begin
      count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_tick.sv
// UART transmitter: start, LSB-first data, optional parity, 1-2 stop bits, paced by i_tick.
module uart_tx_tick
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_tick,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int unsigned BCW = $clog2(DATA_BITS);
  localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 accept_c;
  logic                 run_c;
  logic                 bit_end_c;

  assign o_ready  = (state_q == IDLE) & rst_n;
  assign accept_c = i_valid & o_ready;
  assign run_c    = (state_q != IDLE);
  assign o_tx     = tx_q;
  assign o_busy   = busy_q;
  assign o_done   = done_q;

  uart_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_tick     (i_tick),
    .i_run      (run_c),
    .i_clear    (accept_c),
    .o_bit_end_c(bit_end_c)
  );

  // Next-state and registered-output logic; o_tx always shows the bit of the current state.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (accept_c) begin
          shreg_d   = i_data;
          bit_cnt_d = '0;
          state_d   = START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      START: begin
        if (bit_end_c) begin
          // Shift register is still intact here, so parity comes from the latched byte.
          parity_d = parity_bit(MAX_DATA_BITS'(shreg_q), (PARITY_ODD != 0));
          state_d  = DATA;
          tx_d     = shreg_q[0];
        end
      end
      DATA: begin
        if (bit_end_c) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
            tx_d      = shreg_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end_c) begin
          state_d   = STOP;
          bit_cnt_d = '0;
          tx_d      = 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_end_c) begin
          if (bit_cnt_q == LAST_STOP) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_tick.sv
// Directed bench for uart_tx_tick: four parameterisations sharing clock, reset and tick.
module tb_uart_tx_tick;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_tick;
  logic [7:0] dat  [4];
  logic       vld  [4];
  logic       rdy  [4];
  logic       tx   [4];
  logic       busy [4];
  logic       done [4];

  int checks = 0;
  int errors = 0;
  int acc [4];
  int phase;
  bit tick_en;
  bit tick_seen;

  always #5 clk = ~clk;

  uart_tx_tick u0 (
    .clk(clk), .rst_n(rst_n), .i_tick(i_tick), .i_data(dat[0]), .i_valid(vld[0]),
    .o_ready(rdy[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_done(done[0]));

  uart_tx_tick #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .rst_n(rst_n), .i_tick(i_tick), .i_data(dat[1]), .i_valid(vld[1]),
    .o_ready(rdy[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_done(done[1]));

  uart_tx_tick #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .rst_n(rst_n), .i_tick(i_tick), .i_data(dat[2]), .i_valid(vld[2]),
    .o_ready(rdy[2]), .o_tx(tx[2]), .o_busy(busy[2]), .o_done(done[2]));

  uart_tx_tick #(.STOP_BITS(2)) u3 (
    .clk(clk), .rst_n(rst_n), .i_tick(i_tick), .i_data(dat[3]), .i_valid(vld[3]),
    .o_ready(rdy[3]), .o_tx(tx[3]), .o_busy(busy[3]), .o_done(done[3]));

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic       par;
    int         nbits;
    int         done_clk;
    int         stall_at;
    bit         chg;
    string      nm;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // One clock: count accepts, advance past the edge, then set the tick for the next edge.
  task automatic cyc();
    for (int k = 0; k < 4; k++) if (vld[k] && rdy[k]) acc[k]++;
    tick_seen = i_tick;
    @(posedge clk);
    #1;
    phase  = (phase + 1) % 4;
    i_tick = tick_en && (phase == 0);
  endtask

  function automatic logic [15:0] make_bits(input logic [7:0] d, input logic par, input bit par_en);
    logic [15:0] b;
    b    = '1;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[1+i] = d[i];
    if (par_en) b[9] = par;
    return b;
  endfunction

  // Present a byte so the accepting edge coincides with a tick.
  task automatic start_frame(input int k, input logic [7:0] d, input bit hold);
    int guard = 0;
    while (!(i_tick && rdy[k]) && guard < 100) begin
      cyc();
      guard++;
    end
    chk("accept alignment", int'(guard < 100), 1);
    dat[k] = d;
    vld[k] = 1'b1;
    cyc();
    if (!hold) vld[k] = 1'b0;
  endtask

  // Tick-counting model: after n post-accept ticks the line shows bit n/16.
  task automatic watch_frame(input int k, input logic [15:0] bits, input int nbits,
                             input int done_clk, input int stall_at, input bit chg,
                             input string nm);
    int n    = 0;
    int t    = 0;
    int etx  = 0;
    int ectl = 0;
    bit fin  = 0;
    while (!fin && t < 3000) begin
      if (t > 0 && tick_seen) n++;
      if (n >= nbits * 16) begin
        fin = 1;
      end else begin
        if (tx[k] !== bits[n/16]) etx++;
        if ({busy[k], rdy[k], done[k]} !== 3'b100) ectl++;
        if (chg) dat[k] = 8'($urandom);
        if (t == stall_at) tick_en = 0;
        if (t == stall_at + 100) tick_en = 1;
        cyc();
        t++;
      end
    end
    tick_en = 1;
    chk({nm, " tx cycles wrong"}, etx, 0);
    chk({nm, " busy/ready/done in frame"}, ectl, 0);
    chk({nm, " done clk"}, fin ? t : -1, done_clk);
    chk({nm, " end flags done,busy,ready,tx"}, int'({done[k], busy[k], rdy[k], tx[k]}), 11);
  endtask

  initial begin
    int a0;
    int lows;
    int dones;
    vecs[0] = '{0, 8'hA5, 1'b0, 10, 640, -1, 1'b0, "A5 8N1"};
    vecs[1] = '{1, 8'h07, 1'b1, 11, 704, -1, 1'b0, "07 even"};
    vecs[2] = '{2, 8'h07, 1'b0, 11, 704, -1, 1'b0, "07 odd"};
    vecs[3] = '{0, 8'h00, 1'b0, 10, 640, -1, 1'b0, "00 8N1"};
    vecs[4] = '{0, 8'hFF, 1'b0, 10, 640, -1, 1'b0, "FF 8N1"};
    vecs[5] = '{1, 8'hA5, 1'b0, 11, 704, -1, 1'b0, "A5 even"};
    vecs[6] = '{2, 8'h00, 1'b1, 11, 704, -1, 1'b0, "00 odd"};
    vecs[7] = '{3, 8'h3C, 1'b1, 11, 704, -1, 1'b1, "3C 2stop live data"};
    vecs[8] = '{0, 8'h81, 1'b0, 10, 740, 100, 1'b0, "81 tick stall"};
    vecs[9] = '{1, 8'h80, 1'b1, 11, 704, -1, 1'b0, "80 even"};

    rst_n   = 1'b0;
    i_tick  = 1'b0;
    tick_en = 1;
    phase   = 0;
    for (int k = 0; k < 4; k++) begin
      dat[k] = '0;
      vld[k] = 1'b0;
      acc[k] = 0;
    end

    repeat (3) cyc();
    chk("reset tx,busy,done,ready u0", int'({tx[0], busy[0], done[0], rdy[0]}), 8);
    chk("reset tx,busy,done,ready u3", int'({tx[3], busy[3], done[3], rdy[3]}), 8);
    rst_n = 1'b1;
    cyc();
    chk("post-reset tx,busy,done,ready", int'({tx[0], busy[0], done[0], rdy[0]}), 9);

    for (int i = 0; i < 10; i++) begin
      start_frame(vecs[i].inst, vecs[i].data, 0);
      watch_frame(vecs[i].inst,
                  make_bits(vecs[i].data, vecs[i].par, vecs[i].inst == 1 || vecs[i].inst == 2),
                  vecs[i].nbits, vecs[i].done_clk, vecs[i].stall_at, vecs[i].chg, vecs[i].nm);
      cyc();
      chk({vecs[i].nm, " done pulse end done,busy,tx"},
          int'({done[vecs[i].inst], busy[vecs[i].inst], tx[vecs[i].inst]}), 1);
    end

    // Back-to-back with i_valid held: second start bit right after the done cycle.
    a0 = acc[0];
    start_frame(0, 8'h55, 1);
    dat[0] = 8'hFF;
    watch_frame(0, make_bits(8'h55, 1'b0, 0), 10, 640, -1, 0, "b2b 55");
    cyc();
    vld[0] = 1'b0;
    watch_frame(0, make_bits(8'hFF, 1'b0, 0), 10, 639, -1, 0, "b2b FF");
    repeat (5) cyc();
    chk("b2b accept count", acc[0] - a0, 2);

    // Reset during the data phase of a frame.
    start_frame(0, 8'hC3, 0);
    repeat (200) cyc();
    chk("pre-reset busy,tx", int'({busy[0], tx[0]}), 2);
    rst_n = 1'b0;
    #1;
    chk("async reset tx,busy,done,ready", int'({tx[0], busy[0], done[0], rdy[0]}), 8);
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    chk("ready after mid-frame reset", int'(rdy[0]), 1);

    // Idle ticks must leave every line quiet.
    lows  = 0;
    dones = 0;
    repeat (800) begin
      for (int k = 0; k < 4; k++) begin
        if (tx[k] !== 1'b1 || busy[k] !== 1'b0) lows++;
        if (done[k] !== 1'b0) dones++;
      end
      cyc();
    end
    chk("idle line activity", lows, 0);
    chk("done after reset", dones, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
